arm_seq_alu: RTL and testbench
==============================

Name: arm_seq_alu

Overview:
Parametrised, multi-cycle successor to the core's single-cycle 2-bit-control ALU. It widens the operation set to eight ops, including EOR, RSB and iterative MUL/MLA. It computes over a start/ready/done handshake and returns registered results with NZCV flags. It sits between the datapath's SrcA/SrcB muxes and the result mux; the controller stalls PC update while ready is low.

Parameters:
WIDTH, 32, operand/result width in bits (>= 8)
MUL_STEP, 1, multiplier bits retired per multiply cycle; legal values 1, 2, 4; WIDTH must be divisible by MUL_STEP

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when ready=1
op  input  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 MLA, 111 RSB
a  input  WIDTH  operand A / multiplicand
b  input  WIDTH  operand B / multiplier
c  input  WIDTH  accumulate operand (MLA only)
ready  output  1  idle; can accept start
done  output  1  one-cycle pulse: result/flags updated this cycle
result  output  WIDTH  registered result, held until next completion
flags  output  4  registered {N,Z,C,V}, held with result
flags_arith  output  1  1 when C/V are meaningful (ADD/SUB/RSB); drives FlagW[0] qualification

Behaviour:
- Reset (async, any time, including mid-multiply):
  - state=IDLE; ready=1, done=0, result=0, flags=0, flags_arith=0.
  - Internal multiply registers and count are cleared.
- States: IDLE, MULT.
- Operand capture: op/a/b/c are sampled only at the edge where start&ready=1. Later input changes have no effect.
- IDLE + start, op not in {MUL, MLA}:
  - Result is computed combinationally and registered at that edge.
  - done=1 for the following cycle. State stays IDLE and ready stays 1.
  - Back-to-back starts every cycle are legal; each produces a done pulse one cycle later.
- Arithmetic (WIDTH+1-bit sum):
  - ADD = a+b.
  - SUB = a+~b+1.
  - RSB = b+~a+1.
  - C = carry-out bit WIDTH (for SUB/RSB this means no borrow).
  - V = signed overflow: operands of the effective addition have equal sign and the sum sign differs.
- Logic ops (AND/ORR/EOR): C=0, V=0, flags_arith=0.
- N = result[WIDTH-1]; Z = (result==0), for every op.
- IDLE + start, op in {MUL, MLA}:
  - Load mcand=a, mplier=b, acc = (MLA ? c : 0), count=WIDTH/MUL_STEP.
  - Go to MULT; ready=0 from the next cycle.
- MULT, each edge:
  - acc += mplier[MUL_STEP-1:0]*mcand, truncated to WIDTH.
  - mcand <<= MUL_STEP; mplier >>= MUL_STEP; count--.
  - On the edge where count goes 1->0: result=acc (including this step), flags={N,Z,0,0}, flags_arith=0, done=1 next cycle, state=IDLE, ready=1.
- Latency:
  - Non-multiply ops: 1 cycle.
  - MUL/MLA: N=WIDTH/MUL_STEP cycles from the accepting edge to the edge asserting done, e.g. 32 for WIDTH=32, MUL_STEP=1.
- Multiply result is the low WIDTH bits of a*b(+c); signed and unsigned are identical at this width. Wrap-around is silent.
- start while ready=0 is ignored, with no queuing. done is not asserted again until a new accepted op completes.
- done is never asserted for two consecutive cycles from a single op.
- result and flags are unchanged on cycles without done.

Test Plan:
- Reset: assert reset, release -> ready=1, done=0, result=0, flags=0000; assert reset again mid-idle -> same values.
- ADD a=0xFFFFFFFF b=0x1 -> one cycle later done=1, result=0x0, flags N0 Z1 C1 V0, flags_arith=1; done=0 the cycle after.
- SUB a=0x80000000 b=0x1 then RSB a=0x1 b=0x0 back-to-back:
  - SUB -> 0x7FFFFFFF, N0 Z0 C1 V1.
  - RSB -> 0xFFFFFFFF, N1 Z0 C0 V0.
  - done high on two consecutive cycles, one per op.
- MUL a=7 b=0xFFFFFFFF (MUL_STEP=1):
  - ready=0 for 32 cycles; an ADD start issued at cycle 5 is ignored.
  - done at cycle 32: result=0xFFFFFFF9, flags N1 Z0 C0 V0.
- MLA a=3 b=5 c=0xFFFFFFF1 with MUL_STEP=4 -> done after 8 cycles, result=0x0, flags N0 Z1 C0 V0.
- Reset asserted at cycle 10 of a MUL:
  - Immediately ready=1, done=0, result=0.
  - No done pulse appears later.
  - A subsequent EOR a=0xF0F0F0F0 b=0xFF00FF00 -> 0x0FF00FF0, flags 0000.

Source files
------------

// File: rtl/arm_seq_alu.sv
// arm_seq_alu
//   Multi-cycle ALU with a start/ready/done handshake. Single-cycle ops
//   (ADD, SUB, AND, ORR, EOR, RSB) complete at the accepting edge. MUL and
//   MLA run as an iterative shift-add, retiring MUL_STEP multiplier bits
//   per cycle. The result and the NZCV flags are registered and held until
//   the next completion.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   start        request; accepted only while ready=1
//   op           000 ADD, 001 SUB, 010 AND, 011 ORR,
//                100 EOR, 101 MUL, 110 MLA, 111 RSB
//   a, b, c      operands (a = multiplicand, b = multiplier, c = MLA addend)
//   ready        idle; a start is accepted this cycle
//   done         one-cycle pulse; result/flags were updated at the last edge
//   result       registered result
//   flags        registered {N,Z,C,V}
//   flags_arith  1 when C/V are meaningful (ADD/SUB/RSB)
module arm_seq_alu #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             flags_arith
);

    localparam int unsigned STEPS = WIDTH / MUL_STEP;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_MUL = 3'b101,
        OP_MLA = 3'b110,
        OP_RSB = 3'b111
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [3:0]       flags_nxt;
    logic             arith_nxt;
    logic             done_nxt;

    op_t              op_dec;
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_arith;
    logic [WIDTH-1:0] mstep;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_step;

    assign op_dec = op_t'(op);
    assign ready  = (state == IDLE);

    // Shared adder: SUB and RSB reuse it as x + ~y + 1.
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        case (op_dec)
            OP_SUB: begin
                add_x   = a;
                add_y   = ~b;
                add_cin = 1'b1;
            end
            OP_RSB: begin
                add_x   = b;
                add_y   = ~a;
                add_cin = 1'b1;
            end
            default: ;
        endcase
        sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    end

    always_comb begin
        alu_res   = sum[WIDTH-1:0];
        alu_c     = sum[WIDTH];
        alu_v     = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                    (sum[WIDTH-1] != add_x[WIDTH-1]);
        alu_arith = 1'b1;
        case (op_dec)
            OP_AND, OP_ORR, OP_EOR: begin
                alu_c     = 1'b0;
                alu_v     = 1'b0;
                alu_arith = 1'b0;
                if (op_dec == OP_AND)      alu_res = a & b;
                else if (op_dec == OP_ORR) alu_res = a | b;
                else                       alu_res = a ^ b;
            end
            default: ;
        endcase
    end

    // One shift-add step: low MUL_STEP multiplier bits times the shifted
    // multiplicand, truncated to WIDTH.
    always_comb begin
        mstep                 = '0;
        mstep[MUL_STEP-1:0]   = mplier[MUL_STEP-1:0];
        partial               = mcand * mstep;
        acc_step              = acc + partial;
    end

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        count_nxt  = count;
        result_nxt = result;
        flags_nxt  = flags;
        arith_nxt  = flags_arith;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_dec == OP_MUL || op_dec == OP_MLA) begin
                        mcand_nxt  = a;
                        mplier_nxt = b;
                        acc_nxt    = (op_dec == OP_MLA) ? c : '0;
                        count_nxt  = CW'(STEPS);
                        state_nxt  = MULT;
                    end else begin
                        result_nxt = alu_res;
                        flags_nxt  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                        arith_nxt  = alu_arith;
                        done_nxt   = 1'b1;
                    end
                end
            end
            MULT: begin
                mcand_nxt  = mcand << MUL_STEP;
                mplier_nxt = mplier >> MUL_STEP;
                acc_nxt    = acc_step;
                count_nxt  = count - CW'(1);
                if (count == CW'(1)) begin
                    result_nxt = acc_step;
                    flags_nxt  = {acc_step[WIDTH-1], (acc_step == '0), 2'b00};
                    arith_nxt  = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            count       <= '0;
            result      <= '0;
            flags       <= '0;
            flags_arith <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mcand       <= mcand_nxt;
            mplier      <= mplier_nxt;
            acc         <= acc_nxt;
            count       <= count_nxt;
            result      <= result_nxt;
            flags       <= flags_nxt;
            flags_arith <= arith_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_arm_seq_alu.sv
module tb_arm_seq_alu;

    localparam int unsigned W = 32;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] ORR = 3'b011;
    localparam logic [2:0] EOR = 3'b100;
    localparam logic [2:0] MUL = 3'b101;
    localparam logic [2:0] MLA = 3'b110;
    localparam logic [2:0] RSB = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, start4;
    logic [2:0]   op;
    logic [W-1:0] a, b, c;

    logic         ready, done, flags_arith;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         ready4, done4, arith4;
    logic [W-1:0] result4;
    logic [3:0]   flags4;

    arm_seq_alu #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .c(c),
        .ready(ready), .done(done), .result(result),
        .flags(flags), .flags_arith(flags_arith)
    );

    arm_seq_alu #(.WIDTH(W), .MUL_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op),
        .a(a), .b(b), .c(c),
        .ready(ready4), .done(done4), .result(result4),
        .flags(flags4), .flags_arith(arith4)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         ar;
        string        name;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcyc;
        int lowcnt;
        int spurious;

        vecs[0] = '{ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1'b1, "add_carry_zero"};
        vecs[1] = '{ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1'b1, "add_ovf"};
        vecs[2] = '{SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110, 1'b1, "sub_equal"};
        vecs[3] = '{SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000, 1'b1, "sub_borrow"};
        vecs[4] = '{RSB, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000, 1'b1, "rsb_neg"};
        vecs[5] = '{AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1'b0, "and"};
        vecs[6] = '{ORR, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1'b0, "orr_zero"};
        vecs[7] = '{EOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, 1'b0, "eor"};
        vecs[8] = '{RSB, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b1001, 1'b1, "rsb_ovf"};

        reset = 1'b1; start = 1'b0; start4 = 1'b0;
        op = ADD; a = '0; b = '0; c = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_arith", flags_arith, 0);

        // single-cycle ops, issued back to back
        for (int i = 0; i < 9; i++) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; start = 1'b1;
            tick();
            check({vecs[i].name, "_done"}, done, 1);
            check({vecs[i].name, "_result"}, result, vecs[i].res);
            check({vecs[i].name, "_flags"}, flags, vecs[i].fl);
            check({vecs[i].name, "_arith"}, flags_arith, vecs[i].ar);
            check({vecs[i].name, "_ready"}, ready, 1);
        end
        start = 1'b0;
        tick();
        check("done_falls", done, 0);
        check("result_held", result, 32'h8000_0000);

        // reset while idle
        reset = 1'b1;
        #2;
        check("idle_rst_result", result, 0);
        check("idle_rst_flags", flags, 0);
        check("idle_rst_ready", ready, 1);
        reset = 1'b0;
        tick();

        // SUB then RSB on consecutive cycles
        op = SUB; a = 32'h8000_0000; b = 32'h0000_0001; start = 1'b1;
        tick();
        check("b2b_sub_done", done, 1);
        check("b2b_sub_result", result, 32'h7FFF_FFFF);
        check("b2b_sub_flags", flags, 4'b0011);
        op = RSB; a = 32'h0000_0001; b = 32'h0000_0000;
        tick();
        start = 1'b0;
        check("b2b_rsb_done", done, 1);
        check("b2b_rsb_result", result, 32'hFFFF_FFFF);
        check("b2b_rsb_flags", flags, 4'b1000);
        tick();
        check("b2b_done_falls", done, 0);

        // MUL with an ignored ADD request while busy
        op = MUL; a = 32'h0000_0007; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        lowcnt = 0; dcyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!ready) lowcnt++;
            if (k == 5) begin
                op = ADD; a = 32'h1; b = 32'h1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dcyc = k;
                break;
            end
        end
        start = 1'b0;
        check("mul_latency", dcyc, 32);
        check("mul_ready_low", lowcnt, 32);
        check("mul_result", result, 32'hFFFF_FFF9);
        check("mul_flags", flags, 4'b1000);
        check("mul_arith", flags_arith, 0);
        check("mul_ready_back", ready, 1);
        tick();
        check("mul_done_falls", done, 0);
        check("mul_result_held", result, 32'hFFFF_FFF9);

        // MLA on the 4-bit-step instance
        op = MLA; a = 32'h3; b = 32'h5; c = 32'hFFFF_FFF1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        dcyc = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done4) begin
                dcyc = k;
                break;
            end
        end
        check("mla_latency", dcyc, 8);
        check("mla_result", result4, 0);
        check("mla_flags", flags4, 4'b0100);
        check("mla_arith", arith4, 0);
        tick();
        check("mla_done_falls", done4, 0);

        // reset in the middle of a multiply
        op = MUL; a = 32'h0000_0007; b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("midmul_busy", ready, 0);
        reset = 1'b1;
        #1;
        check("midmul_rst_ready", ready, 1);
        check("midmul_rst_done", done, 0);
        check("midmul_rst_result", result, 0);
        check("midmul_rst_flags", flags, 0);
        #2;
        reset = 1'b0;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) spurious++;
        end
        check("midmul_no_done", spurious, 0);
        op = EOR; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; start = 1'b1;
        tick();
        start = 1'b0;
        check("post_eor_done", done, 1);
        check("post_eor_result", result, 32'h0FF0_0FF0);
        check("post_eor_flags", flags, 4'b0000);
        check("post_eor_arith", flags_arith, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
